// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequencing/configuration front-end for the pwm core.
// Holds the live period (committed from a shadow register at frame wrap) and
// per-channel live duties that ramp toward software targets once per frame.
// A private frame counter mirrors the pwm core counter (same clk/rst_n).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       1 = run ramps, 0 = hold all live duties at 0
//   period_we    shadow period write strobe, data on period_in
//   duty_we      target/step write strobe for channel duty_sel
//   target_in    target duty for the selected channel
//   step_in      per-frame ramp step for the selected channel (0 = jump)
//   period       live period to the pwm core
//   duty         live duties, ch i at [(i+1)*W-1 -: W], MSB tied 0
//   frame_tick   high on the frame wrap cycle
//   busy         bit i high while live duty i differs from its target
module pwm_ramp_ctrl #(
    parameter int unsigned CORE_WIDTH        = 4,
    parameter int unsigned PWM_COUNTER_WIDTH = 16,
    parameter logic [PWM_COUNTER_WIDTH-1:0] PERIOD_RESET = 16'hFFFF,
    localparam int unsigned SEL_W = (CORE_WIDTH > 1) ? $clog2(CORE_WIDTH) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        enable,
    input  logic                                        period_we,
    input  logic [PWM_COUNTER_WIDTH-1:0]                period_in,
    input  logic                                        duty_we,
    input  logic [SEL_W-1:0]                            duty_sel,
    input  logic [PWM_COUNTER_WIDTH-1:0]                target_in,
    input  logic [PWM_COUNTER_WIDTH-1:0]                step_in,
    output logic [PWM_COUNTER_WIDTH-1:0]                period,
    output logic [PWM_COUNTER_WIDTH*CORE_WIDTH:0]       duty,
    output logic                                        frame_tick,
    output logic [CORE_WIDTH-1:0]                       busy
);

    localparam int unsigned W     = PWM_COUNTER_WIDTH;
    // One extra bit so the counter can reach period+1 even at the maximum period.
    localparam int unsigned CNT_W = W + 1;

    typedef enum logic {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     period_q, period_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     cur_q  [CORE_WIDTH];
    logic [W-1:0]     cur_d  [CORE_WIDTH];
    logic [W-1:0]     tgt_q  [CORE_WIDTH];
    logic [W-1:0]     tgt_d  [CORE_WIDTH];
    logic [W-1:0]     step_q [CORE_WIDTH];
    logic [W-1:0]     step_d [CORE_WIDTH];
    logic             tick_c;

    // Wrap condition, identical to the pwm core counter.
    assign tick_c = (cnt_q > CNT_W'(period_q));

    // One ramp step toward tgt; arithmetic in W+1 bits so it never wraps.
    function automatic logic [W-1:0] ramp_next(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt,
                                               input logic [W-1:0] step);
        logic [W:0] sum;
        logic [W:0] gap;
        ramp_next = cur;
        sum = {1'b0, cur} + {1'b0, step};
        gap = {1'b0, cur} - {1'b0, tgt};
        if (step == '0) begin
            ramp_next = tgt;
        end else if (cur < tgt) begin
            ramp_next = (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
        end else if (cur > tgt) begin
            ramp_next = ({1'b0, step} >= gap) ? tgt : (cur - step);
        end
    endfunction

    // Next-state: FSM, frame counter, period commit, ramps and register writes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        period_d = period_q;
        shadow_d = shadow_q;
        for (int i = 0; i < int'(CORE_WIDTH); i++) begin
            cur_d[i]  = cur_q[i];
            tgt_d[i]  = tgt_q[i];
            step_d[i] = step_q[i];
        end

        state_d = enable ? ST_RUN : ST_DISABLED;

        if (tick_c) begin
            cnt_d    = '0;
            period_d = shadow_q;
        end
        if (period_we) begin
            shadow_d = period_in;
        end

        for (int i = 0; i < int'(CORE_WIDTH); i++) begin
            // Ramp uses pre-write target/step; a first RUN frame starts from 0.
            if (!enable) begin
                cur_d[i] = '0;
            end else if ((state_q == ST_RUN) && tick_c) begin
                cur_d[i] = ramp_next(cur_q[i], tgt_q[i], step_q[i]);
            end
            // Out-of-range selects match no channel and are dropped.
            if (duty_we && (duty_sel == SEL_W'(i))) begin
                tgt_d[i]  = target_in;
                step_d[i] = step_in;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_DISABLED;
            cnt_q    <= '0;
            period_q <= PERIOD_RESET;
            shadow_q <= PERIOD_RESET;
            for (int i = 0; i < int'(CORE_WIDTH); i++) begin
                cur_q[i]  <= '0;
                tgt_q[i]  <= '0;
                step_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
            for (int i = 0; i < int'(CORE_WIDTH); i++) begin
                cur_q[i]  <= cur_d[i];
                tgt_q[i]  <= tgt_d[i];
                step_q[i] <= step_d[i];
            end
        end
    end

    // Output mapping straight from registers.
    assign period     = period_q;
    assign frame_tick = tick_c;
    assign duty[W*CORE_WIDTH] = 1'b0;

    for (genvar g = 0; g < int'(CORE_WIDTH); g++) begin : g_ch
        assign duty[(g+1)*W-1 -: W] = cur_q[g];
        assign busy[g]              = (cur_q[g] != tgt_q[g]);
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a frame-level model.
// The main instance uses a short reset period so frames stay short; a second
// instance with default parameters pins the 16'hFFFF reset value.
module tb_pwm_ramp_ctrl;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;
    localparam logic [15:0] P_RST = 16'd63;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        period_we = 1'b0;
    logic [15:0] period_in = '0;
    logic        duty_we = 1'b0;
    logic [1:0]  duty_sel = '0;
    logic [15:0] target_in = '0;
    logic [15:0] step_in = '0;

    logic [15:0] period, d_period;
    logic [64:0] duty, d_duty;
    logic        frame_tick, d_frame_tick;
    logic [3:0]  busy, d_busy;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    pwm_ramp_ctrl #(.CORE_WIDTH(NCH), .PWM_COUNTER_WIDTH(W), .PERIOD_RESET(P_RST)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .period_we(period_we), .period_in(period_in),
        .duty_we(duty_we), .duty_sel(duty_sel), .target_in(target_in), .step_in(step_in),
        .period(period), .duty(duty), .frame_tick(frame_tick), .busy(busy)
    );

    pwm_ramp_ctrl dut_def (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .period_we(period_we), .period_in(period_in),
        .duty_we(duty_we), .duty_sel(duty_sel), .target_in(target_in), .step_in(step_in),
        .period(d_period), .duty(d_duty), .frame_tick(d_frame_tick), .busy(d_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt, m_period, m_shadow;
    int m_cur[NCH], m_tgt[NCH], m_step[NCH];
    int n_cur[NCH];
    bit m_en_prev, m_tk;

    function automatic int ramp(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s < t) ? c + s : t;
        if (c > t) return (c - s > t) ? c - s : t;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_period = int'(P_RST); m_shadow = int'(P_RST); m_en_prev = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_cur[i] = 0; m_tgt[i] = 0; m_step[i] = 0;
            end
        end else begin
            m_tk = (m_cnt > m_period);
            for (int i = 0; i < NCH; i++) begin
                n_cur[i] = m_cur[i];
                if (!enable) n_cur[i] = 0;
                else if (m_en_prev && m_tk) n_cur[i] = ramp(m_cur[i], m_tgt[i], m_step[i]);
            end
            if (duty_we) begin
                m_tgt[duty_sel]  = int'(target_in);
                m_step[duty_sel] = int'(step_in);
            end
            for (int i = 0; i < NCH; i++) m_cur[i] = n_cur[i];
            m_cnt = m_tk ? 0 : m_cnt + 1;
            if (m_tk) m_period = m_shadow;
            if (period_we) m_shadow = int'(period_in);
            m_en_prev = enable;
        end
    end

    logic [3:0] e_busy;
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            check("period", period, 96'(m_period));
            for (int i = 0; i < NCH; i++) begin
                check($sformatf("duty%0d", i), duty[i*16 +: 16], 96'(m_cur[i]));
                e_busy[i] = (m_cur[i] != m_tgt[i]);
            end
            check("duty_msb", duty[64], 96'(0));
            check("frame_tick", frame_tick, 96'(m_cnt > m_period));
            check("busy", busy, e_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int limit);
        int n;
        n = 0;
        while (!frame_tick && n < limit) begin
            cyc();
            n++;
        end
        check("wait_tick", frame_tick, 96'(1));
    endtask

    task automatic wr_period(input logic [15:0] p);
        period_in = p; period_we = 1'b1;
        cyc();
        period_we = 1'b0;
    endtask

    task automatic wr_duty(input int sel, input logic [15:0] tg, input logic [15:0] st);
        duty_sel = 2'(sel); target_in = tg; step_in = st; duty_we = 1'b1;
        cyc();
        duty_we = 1'b0;
    endtask

    function automatic logic [15:0] dch(input int i);
        return duty[i*16 +: 16];
    endfunction

    function automatic int frame_len();
        return 0;
    endfunction

    initial begin
        int n;
        // Reset and reset values.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", period, 96'(P_RST));
        check("rst_duty", duty, 96'(0));
        check("rst_busy", busy, 96'(0));
        check("rst_tick", frame_tick, 96'(0));
        check("rst_def_period", d_period, 96'(16'hFFFF));
        rst_n = 1'b1;
        chk_on = 1'b1;
        cyc();

        // Period commit at frame wrap, write on tick cycle lands next frame.
        wr_period(16'd10);
        wait_tick(80);
        period_in = 16'd4; period_we = 1'b1;
        cyc();
        period_we = 1'b0;
        check("period_10", period, 96'(10));
        n = 1;
        while (!frame_tick && n < 40) begin cyc(); n++; end
        check("frame_len_12", 96'(n), 96'(12));
        cyc();
        check("period_4", period, 96'(4));
        n = 1;
        while (!frame_tick && n < 40) begin cyc(); n++; end
        check("frame_len_6", 96'(n), 96'(6));

        // Ramp up on channel 0.
        wr_period(16'd99);
        wait_tick(10);
        cyc();
        check("period_99", period, 96'(99));
        enable = 1'b1;
        wr_duty(0, 16'd50, 16'd20);
        wait_tick(120); cyc();
        check("up_20", dch(0), 96'(20));
        check("up_busy", busy[0], 96'(1));
        wait_tick(120); cyc();
        check("up_40", dch(0), 96'(40));
        wait_tick(120); cyc();
        check("up_50", dch(0), 96'(50));
        check("up_idle", busy[0], 96'(0));

        // Ramp down with clamping at the target, no underflow.
        wr_duty(1, 16'd50, 16'd0);
        wait_tick(120); cyc();
        check("dn_jump50", dch(1), 96'(50));
        wr_duty(1, 16'd5, 16'd30);
        wait_tick(120); cyc();
        check("dn_20", dch(1), 96'(20));
        wait_tick(120); cyc();
        check("dn_5", dch(1), 96'(5));
        wr_duty(1, 16'd0, 16'hFFFF);
        wait_tick(120); cyc();
        check("dn_0", dch(1), 96'(0));
        check("dn_idle", busy[1], 96'(0));

        // Upper saturation, no wrap.
        wr_duty(2, 16'hFFF0, 16'd0);
        wait_tick(120); cyc();
        check("ov_fff0", dch(2), 96'(16'hFFF0));
        wr_duty(2, 16'hFFFF, 16'h0100);
        wait_tick(120); cyc();
        check("ov_ffff", dch(2), 96'(16'hFFFF));

        // Enable toggle: duties drop at once, ramps restart from 0.
        wr_duty(3, 16'd1000, 16'd100);
        wait_tick(120); cyc();
        check("en_100", dch(3), 96'(100));
        enable = 1'b0;
        cyc();
        check("dis_duty", duty, 96'(0));
        check("dis_busy", busy, 96'(4'b1101));
        enable = 1'b1;
        cyc();
        wait_tick(120); cyc();
        check("re_ch0", dch(0), 96'(20));
        check("re_ch1", dch(1), 96'(0));
        check("re_ch2", dch(2), 96'(16'h0100));
        check("re_ch3", dch(3), 96'(100));

        // Randomized phase, model checks every cycle.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            period_we = ($urandom_range(0, 49) == 0);
            period_in = 16'($urandom_range(0, 30));
            duty_we   = ($urandom_range(0, 9) == 0);
            duty_sel  = 2'($urandom_range(0, 3));
            target_in = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            case ($urandom_range(0, 2))
                0: step_in = 16'd0;
                1: step_in = 16'($urandom_range(1, 10));
                default: step_in = 16'($urandom);
            endcase
            cyc();
        end
        period_we = 1'b0; duty_we = 1'b0;

        // Asynchronous reset in the middle of a ramp.
        enable = 1'b1;
        wr_duty(0, 16'h8000, 16'd1);
        wait_tick(200); cyc();
        #3 rst_n = 1'b0;
        #1;
        check("arst_period", period, 96'(P_RST));
        check("arst_duty", duty, 96'(0));
        check("arst_busy", busy, 96'(0));
        check("arst_tick", frame_tick, 96'(0));
        check("arst_def_period", d_period, 96'(16'hFFFF));
        check("arst_def_duty", d_duty, 96'(0));
        check("arst_def_busy", d_busy, 96'(0));
        enable = 1'b0;
        cyc();
        rst_n = 1'b1;
        n = 0;
        while (!frame_tick && n < 100) begin cyc(); n++; end
        check("realign", 96'(n), 96'(int'(P_RST) + 1));
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
